// File: rtl/tc_pkg.sv
// Shared types and register-map constants for the memory-mapped timer/counter.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [31:0] CTRL_OFF   = 32'h0;
    localparam logic [31:0] PRESET_OFF = 32'h4;
    localparam logic [31:0] COUNT_OFF  = 32'h8;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        merge_bytes = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merge_bytes[8*i +: 8] = new_val[8*i +: 8];
        end
    endfunction

    // Only 2'b01 reloads; every other encoding, including 2'b1x, is one-shot.
    function automatic logic is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// CPU data-bus view of the timer: word address, byte enables, write data, read data and irq.
interface timer_counter_if;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, byteen, wdata, input rdata, irq);
    modport slave  (input addr, byteen, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter.sv
// Timer/counter peripheral: CTRL/PRESET/COUNT register window, countdown FSM and
// level interrupt that software acknowledges by writing CTRL (one-shot) or that self-clears (reload).
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

    localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFF;
    localparam logic [31:0] PRESET_ADDR = BASE_ADDR + PRESET_OFF;
    localparam logic [31:0] COUNT_ADDR  = BASE_ADDR + COUNT_OFF;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic [31:0] word_addr;
    logic        sel_ctrl, sel_preset, sel_count;
    logic        wr_ctrl, wr_preset;
    logic        flag_set, flag_clr;

    assign word_addr  = {bus.addr[31:2], 2'b00};
    assign sel_ctrl   = (word_addr == CTRL_ADDR);
    assign sel_preset = (word_addr == PRESET_ADDR);
    assign sel_count  = (word_addr == COUNT_ADDR);
    assign wr_ctrl    = sel_ctrl & (|bus.byteen);
    assign wr_preset  = sel_preset & (|bus.byteen);

    assign bus.irq = flag_q & ctrl_q[IM_BIT];

    always_comb begin
        bus.rdata = '0;
        if (sel_ctrl)        bus.rdata = {28'd0, ctrl_q};
        else if (sel_preset) bus.rdata = preset_q;
        else if (sel_count)  bus.rdata = count_q;
    end

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_set = 1'b0;
        flag_clr = 1'b0;

        if (wr_ctrl && bus.byteen[0]) ctrl_d = bus.wdata[3:0];
        if (wr_preset)                preset_d = merge_bytes(preset_q, bus.wdata, bus.byteen);

        case (state_q)
            IDLE: begin
                if (ctrl_q[EN_BIT]) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[EN_BIT]) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = '0;
                    flag_set = 1'b1;
                    state_d  = INT;
                end
            end
            INT: begin
                // The FSM's EN clear comes after the register write so it overrides a concurrent EN=1.
                if (is_reload(ctrl_q[MODE_MSB:MODE_LSB])) flag_clr = 1'b1;
                else                                      ctrl_d[EN_BIT] = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Setting beats a same-edge acknowledge so an interrupt is never lost.
        flag_d = flag_set | (flag_q & ~(wr_ctrl | flag_clr));
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: vector table, hand-written corner sequences and a
// randomized run against a time-based reference model of the countdown.
module tb_timer_counter;

    localparam logic [31:0] BASE   = 32'h0000_7f00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timer_counter_if bus_if ();

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: counting is tracked as elapsed edges since the run started.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count, m_loaded;
    logic        m_flag, m_active;
    logic        m_valid = 1'b0;
    longint      m_edge  = 0;
    longint      m_start = 0;

    logic [31:0] s_rd;
    logic        s_irq;

    typedef struct {
        logic        rst;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        if (w == A_CTRL) return {28'd0, m_ctrl};
        if (w == A_PRE)  return m_preset;
        if (w == A_CNT)  return m_count;
        return 32'd0;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd);
        logic [31:0] w;
        logic        wr_ctrl, wr_pre, set_f, clr_f;
        logic [3:0]  n_ctrl;
        logic [31:0] n_pre;
        longint      k, p;
        m_edge++;
        if (r) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_loaded = '0;
            m_flag = 1'b0; m_active = 1'b0; m_valid = 1'b1;
            return;
        end
        w       = a & ~32'd3;
        wr_ctrl = (be != 4'h0) && (w == A_CTRL);
        wr_pre  = (be != 4'h0) && (w == A_PRE);
        n_ctrl  = m_ctrl;
        if (wr_ctrl && be[0]) n_ctrl = wd[3:0];
        n_pre = m_preset;
        for (int b = 0; b < 4; b++) if (wr_pre && be[b]) n_pre[8*b +: 8] = wd[8*b +: 8];
        set_f = 1'b0;
        clr_f = 1'b0;
        if (!m_active) begin
            if (m_ctrl[0]) begin
                m_active = 1'b1;
                m_start  = m_edge;
            end
        end else begin
            k = m_edge - m_start;
            if (k == 1) begin
                m_loaded = m_preset;
                m_count  = m_preset;
            end else begin
                p = (m_loaded == 0) ? 1 : longint'(m_loaded);
                if (k <= p + 1) begin
                    if (!m_ctrl[0]) m_active = 1'b0;
                    else begin
                        m_count = (longint'(m_loaded) > k - 1) ? m_loaded - 32'(k - 1) : 32'd0;
                        if (k == p + 1) set_f = 1'b1;
                    end
                end else begin
                    if (m_ctrl[2:1] == 2'b01) clr_f = 1'b1;
                    else                      n_ctrl[0] = 1'b0;
                    m_active = 1'b0;
                end
            end
        end
        m_flag   = set_f | (m_flag & !(wr_ctrl | clr_f));
        m_ctrl   = n_ctrl;
        m_preset = n_pre;
    endtask

    // One bus cycle: drive at negedge, sample before the edge, then advance the model on the edge.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic iq);
        @(negedge clk);
        reset         = r;
        bus_if.addr   = a;
        bus_if.byteen = be;
        bus_if.wdata  = wd;
        #1;
        rd = bus_if.rdata;
        iq = bus_if.irq;
        if (m_valid) begin
            check("model_rdata", rd, m_rdata(a));
            check("model_irq", {31'd0, iq}, {31'd0, m_flag & m_ctrl[3]});
        end
        @(posedge clk);
        model_step(r, a, be, wd);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, a, 4'h0, 32'h0, s_rd, s_irq);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        cyc(1'b0, a, be, wd, s_rd, s_irq);
    endtask

    initial begin
        logic        r;
        logic [31:0] a, wd;
        logic [3:0]  be;
        int          sel;

        vecs = '{
            '{1'b0, A_CTRL,        4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_PRE,         4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_PRE,         4'hf, 32'h2,         32'h0,         1'b0},
            '{1'b0, A_PRE,         4'h0, 32'h0,         32'h2,         1'b0},
            '{1'b0, A_CTRL,        4'hf, 32'h1,         32'h0,         1'b0},
            '{1'b0, A_CTRL,        4'h0, 32'h0,         32'h1,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h2,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h1,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_CTRL,        4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_CTRL,        4'hf, 32'h8,         32'h0,         1'b0},
            '{1'b0, A_CTRL,        4'h0, 32'h0,         32'h8,         1'b0},
            '{1'b0, A_CNT,         4'hf, 32'hffff_ffff, 32'h0,         1'b0},
            '{1'b0, A_CNT,         4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_PRE,         4'h1, 32'h1234_5678, 32'h2,         1'b0},
            '{1'b0, A_PRE,         4'h0, 32'h0,         32'h78,        1'b0},
            '{1'b0, A_PRE,         4'ha, 32'haabb_ccdd, 32'h78,        1'b0},
            '{1'b0, A_PRE,         4'h0, 32'h0,         32'haa00_cc78, 1'b0},
            '{1'b0, BASE + 32'hc,  4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, 32'h0000_7e00, 4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, BASE + 32'h10, 4'hf, 32'h0,         32'h0,         1'b0},
            '{1'b0, A_PRE,         4'h0, 32'h0,         32'haa00_cc78, 1'b0},
            '{1'b0, A_CTRL,        4'hf, 32'hffff_fff0, 32'h8,         1'b0},
            '{1'b0, A_CTRL,        4'h0, 32'h0,         32'h0,         1'b0},
            '{1'b0, BASE + 32'h6,  4'h0, 32'h0,         32'haa00_cc78, 1'b0}
        };

        reset = 1'b1;
        bus_if.addr = '0; bus_if.byteen = '0; bus_if.wdata = '0;
        cyc(1'b1, A_CTRL, 4'h0, 32'h0, s_rd, s_irq);
        cyc(1'b1, A_CTRL, 4'h0, 32'h0, s_rd, s_irq);

        // Register access, one-shot with IM=0, read-only COUNT, byte writes, window decode.
        for (int i = 0; i < 27; i++) begin
            cyc(vecs[i].rst, vecs[i].addr, vecs[i].be, vecs[i].wd, s_rd, s_irq);
            check($sformatf("vec%0d_rdata", i), s_rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, s_irq}, {31'd0, vecs[i].exp_irq});
        end

        // One-shot with IM: irq rises on E0+7, holds until a CTRL write.
        wr(A_PRE, 4'hf, 32'd5);
        wr(A_CTRL, 4'hf, 32'h9);
        for (int j = 1; j <= 10; j++) begin
            rd(A_CTRL);
            check("oneshot_irq_rise", {31'd0, s_irq}, {31'd0, j >= 8});
            if (j == 10) check("oneshot_ctrl_en_cleared", s_rd, 32'h8);
        end
        rd(A_CNT);
        check("oneshot_count_zero", s_rd, 32'h0);
        check("oneshot_irq_held", {31'd0, s_irq}, 32'd1);
        wr(A_CTRL, 4'hf, 32'h8);
        for (int j = 0; j < 5; j++) begin
            rd(A_CTRL);
            check("oneshot_ack_irq_low", {31'd0, s_irq}, 32'd0);
        end

        // Acknowledge landing on the set edge, then a CTRL write during INT.
        wr(A_PRE, 4'hf, 32'd2);
        wr(A_CTRL, 4'hf, 32'h9);
        for (int j = 1; j <= 3; j++) rd(A_CNT);
        wr(A_CTRL, 4'hf, 32'h9);
        wr(A_CTRL, 4'hf, 32'h9);
        check("collide_set_wins", {31'd0, s_irq}, 32'd1);
        rd(A_CTRL);
        check("int_write_en_overridden", s_rd, 32'h8);
        check("int_write_acks", {31'd0, s_irq}, 32'd0);
        for (int j = 0; j < 4; j++) rd(A_CNT);
        check("no_restart_after_oneshot", s_rd, 32'h0);

        // Auto-reload: period P+3, PRESET change applies from the following load.
        wr(A_PRE, 4'hf, 32'd3);
        wr(A_CTRL, 4'hf, 32'hB);
        for (int j = 1; j <= 60; j++) begin
            if (j == 28) wr(A_PRE, 4'hf, 32'd10);
            else         rd(A_CNT);
            check("reload_irq_pulse", {31'd0, s_irq},
                  {31'd0, (j <= 30) ? (j % 6 == 0) : ((j - 30) % 13 == 0)});
        end
        wr(A_CTRL, 4'hf, 32'h0);
        for (int j = 0; j < 3; j++) rd(A_CNT);

        // Disable mid-count freezes COUNT; re-enable restarts from PRESET.
        wr(A_PRE, 4'hf, 32'd100);
        wr(A_CTRL, 4'hf, 32'h9);
        for (int j = 1; j <= 20; j++) begin
            rd(A_CNT);
            check("freeze_no_irq", {31'd0, s_irq}, 32'd0);
            if (j == 20) check("freeze_count_before", s_rd, 32'd83);
        end
        wr(A_CTRL, 4'hf, 32'h8);
        for (int j = 0; j < 4; j++) begin
            rd(A_CNT);
            check("freeze_count_81", s_rd, 32'd81);
        end
        wr(A_CTRL, 4'hf, 32'h9);
        rd(A_CNT); check("reen_hold1", s_rd, 32'd81);
        rd(A_CNT); check("reen_hold2", s_rd, 32'd81);
        rd(A_CNT); check("reen_reload", s_rd, 32'd100);
        rd(A_CNT); check("reen_dec", s_rd, 32'd99);
        wr(A_CTRL, 4'hf, 32'h0);
        for (int j = 0; j < 3; j++) rd(A_CNT);

        // Reset during count, then a byte write to PRESET.
        wr(A_PRE, 4'hf, 32'd50);
        wr(A_CTRL, 4'hf, 32'h1);
        for (int j = 1; j <= 12; j++) rd(A_CNT);
        cyc(1'b1, A_CNT, 4'h0, 32'h0, s_rd, s_irq);
        check("reset_seen_at_40", s_rd, 32'd40);
        rd(A_CNT);  check("reset_count", s_rd, 32'h0);
        check("reset_irq", {31'd0, s_irq}, 32'd0);
        rd(A_CTRL); check("reset_ctrl", s_rd, 32'h0);
        rd(A_PRE);  check("reset_preset", s_rd, 32'h0);
        rd(A_CNT);  check("reset_idle_count", s_rd, 32'h0);
        wr(A_PRE, 4'h1, 32'h1234_5678);
        rd(A_PRE);  check("byte_write_preset", s_rd, 32'h0000_0078);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0, 3:    a = A_CTRL;
                1, 4:    a = A_PRE;
                2:       a = A_CNT;
                default: a = ($urandom_range(0, 1) == 0) ? BASE + 32'hc : BASE - 32'h4;
            endcase
            a  = a + 32'($urandom_range(0, 3));
            be = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (sel == 1 || sel == 4) wd = 32'($urandom_range(0, 9));
            else                      wd = $urandom;
            cyc(r, a, be, wd, s_rd, s_irq);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
